// File: rtl/plic_pkg.sv
// Shared constants and scan-state encoding for the PLIC claim/priority logic.
package plic_pkg;

  localparam int unsigned ID_W      = 5;
  localparam int unsigned PRIO_W    = 5;
  localparam int unsigned CONTEXTS  = 3;
  localparam int unsigned SRC_W     = 32;
  localparam int unsigned CTX_IDX_W = $clog2(CONTEXTS);

  localparam int unsigned CTX_M = 0;
  localparam int unsigned CTX_S = 1;
  localparam int unsigned CTX_U = 2;

  typedef enum logic {
    SCAN    = 1'b0,
    PUBLISH = 1'b1
  } scan_state_e;

endpackage

// File: rtl/plic_rr_arbiter.sv
// Round-robin grant across N requesters; search starts just after the last granted index.
module plic_rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt_c,
  output logic [IDX_W-1:0] gnt_idx_c,
  output logic             gnt_vld_c
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    gnt_vld_c = 1'b0;
    ptr_d     = ptr_q;
    for (int unsigned off = 0; off < N; off++) begin
      logic [IDX_W-1:0] idx;
      idx = IDX_W'((int'(ptr_q) + off) % N);
      if (!gnt_vld_c && req[idx]) begin
        gnt_vld_c  = 1'b1;
        gnt_idx_c  = idx;
        gnt_c[idx] = 1'b1;
      end
    end
    if (gnt_vld_c) begin
      ptr_d = (gnt_idx_c == IDX_W'(N - 1)) ? '0 : gnt_idx_c + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/plic_claim_arbiter.sv
// Per-context serial priority scan, claim sequencing and completion filtering for the PLIC.
// PLIC_FAST_SCAN_EN: scan two sources per cycle instead of one.
module plic_claim_arbiter
  import plic_pkg::*;
#(
  parameter int unsigned INTERRUPTS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SRC_W-1:0]             pending,
  input  logic [SRC_W*PRIO_W-1:0]      prio_flat,
  input  logic [CONTEXTS*SRC_W-1:0]    enable_flat,
  input  logic [CONTEXTS*PRIO_W-1:0]   thresh_flat,
  input  logic [CONTEXTS-1:0]          claim_req,
  output logic [CONTEXTS-1:0]          claim_ack,
  output logic [ID_W-1:0]              claim_id,
  output logic                         clr_vld,
  output logic [ID_W-1:0]              clr_id,
  input  logic [CONTEXTS-1:0]          complete_req,
  input  logic [ID_W-1:0]              complete_id,
  output logic                         cmpl_vld,
  output logic [ID_W-1:0]              cmpl_id,
  output logic [CONTEXTS*ID_W-1:0]     best_id_flat,
  output logic [CONTEXTS-1:0]          eip
);

`ifdef PLIC_FAST_SCAN_EN
  localparam int unsigned STEP = 2;
`else
  localparam int unsigned STEP = 1;
`endif
  localparam logic [ID_W:0]   MAX_K  = (ID_W+1)'(INTERRUPTS);
  localparam logic [ID_W-1:0] MAX_ID = ID_W'(INTERRUPTS);

  logic [SRC_W-1:0][PRIO_W-1:0]    prio_a;
  logic [CONTEXTS-1:0][SRC_W-1:0]  en_a;
  logic [CONTEXTS-1:0][PRIO_W-1:0] thr_a;
  assign prio_a = prio_flat;
  assign en_a   = enable_flat;
  assign thr_a  = thresh_flat;

  scan_state_e                     state_q, state_d;
  logic [ID_W-1:0]                 k_q, k_d;
  logic [CONTEXTS-1:0][ID_W-1:0]   cand_id_q, cand_id_d;
  logic [CONTEXTS-1:0][PRIO_W-1:0] cand_prio_q, cand_prio_d;
  logic [CONTEXTS-1:0][ID_W-1:0]   best_q, best_d;
  logic [CONTEXTS-1:0]             eip_q, eip_d;
  logic [CONTEXTS-1:0]             claim_ack_q, claim_ack_d;
  logic [ID_W-1:0]                 claim_id_q, claim_id_d;
  logic                            clr_vld_q, clr_vld_d;
  logic [ID_W-1:0]                 clr_id_q, clr_id_d;
  logic                            cmpl_vld_q, cmpl_vld_d;
  logic [ID_W-1:0]                 cmpl_id_q, cmpl_id_d;

  logic [CONTEXTS-1:0]             gnt_c;
  logic [CTX_IDX_W-1:0]            gnt_idx_c;
  logic                            gnt_vld_c;
  logic [ID_W:0]                   kk, kn;
  logic [ID_W-1:0]                 id;
  logic [CTX_IDX_W-1:0]            cmpl_ctx;

  // A context whose ack is in flight still holds its request; keep it out of arbitration.
  plic_rr_arbiter #(.N(CONTEXTS), .IDX_W(CTX_IDX_W)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (claim_req & ~claim_ack_q),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c),
    .gnt_vld_c (gnt_vld_c)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cand_id_d   = cand_id_q;
    cand_prio_d = cand_prio_q;
    best_d      = best_q;
    eip_d       = eip_q;
    claim_ack_d = '0;
    claim_id_d  = '0;
    clr_vld_d   = 1'b0;
    clr_id_d    = '0;
    cmpl_vld_d  = 1'b0;
    cmpl_id_d   = '0;
    kk          = '0;
    kn          = '0;
    id          = '0;
    cmpl_ctx    = '0;

    unique case (state_q)
      SCAN: begin
        for (int unsigned s = 0; s < STEP; s++) begin
          kk = {1'b0, k_q} + (ID_W+1)'(s);
          id = kk[ID_W-1:0];
          // Skip the ID being cleared this cycle: the gateway has not dropped it yet.
          if (kk <= MAX_K && pending[id] && !(clr_vld_q && clr_id_q == id)) begin
            for (int unsigned c = 0; c < CONTEXTS; c++) begin
              if (en_a[c][id] && prio_a[id] > thr_a[c] && prio_a[id] > cand_prio_d[c]) begin
                cand_id_d[c]   = id;
                cand_prio_d[c] = prio_a[id];
              end
            end
          end
        end
        kn = {1'b0, k_q} + (ID_W+1)'(STEP);
        if (kn > MAX_K) state_d = PUBLISH;
        else            k_d     = kn[ID_W-1:0];
      end
      PUBLISH: begin
        best_d = cand_id_q;
        for (int unsigned c = 0; c < CONTEXTS; c++) eip_d[c] = (cand_id_q[c] != '0);
        cand_id_d   = '0;
        cand_prio_d = '0;
        k_d         = ID_W'(1);
        state_d     = SCAN;
      end
      default: state_d = SCAN;
    endcase

    // Claim retires the ID everywhere and restarts the scan, overriding any publish.
    if (gnt_vld_c) begin
      claim_ack_d = gnt_c;
      claim_id_d  = best_q[gnt_idx_c];
      if (best_q[gnt_idx_c] != '0) begin
        clr_vld_d = 1'b1;
        clr_id_d  = best_q[gnt_idx_c];
        for (int unsigned c = 0; c < CONTEXTS; c++) begin
          best_d[c] = (best_q[c] == best_q[gnt_idx_c]) ? '0 : best_q[c];
          eip_d[c]  = (best_d[c] != '0);
        end
        cand_id_d   = '0;
        cand_prio_d = '0;
        k_d         = ID_W'(1);
        state_d     = SCAN;
      end
    end

    for (int c = CONTEXTS - 1; c >= 0; c--) begin
      if (complete_req[c]) cmpl_ctx = CTX_IDX_W'(c);
    end
    if (complete_req != '0 && complete_id != '0 && complete_id <= MAX_ID &&
        en_a[cmpl_ctx][complete_id]) begin
      cmpl_vld_d = 1'b1;
      cmpl_id_d  = complete_id;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SCAN;
      k_q         <= ID_W'(1);
      cand_id_q   <= '0;
      cand_prio_q <= '0;
      best_q      <= '0;
      eip_q       <= '0;
      claim_ack_q <= '0;
      claim_id_q  <= '0;
      clr_vld_q   <= 1'b0;
      clr_id_q    <= '0;
      cmpl_vld_q  <= 1'b0;
      cmpl_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cand_id_q   <= cand_id_d;
      cand_prio_q <= cand_prio_d;
      best_q      <= best_d;
      eip_q       <= eip_d;
      claim_ack_q <= claim_ack_d;
      claim_id_q  <= claim_id_d;
      clr_vld_q   <= clr_vld_d;
      clr_id_q    <= clr_id_d;
      cmpl_vld_q  <= cmpl_vld_d;
      cmpl_id_q   <= cmpl_id_d;
    end
  end

  assign claim_ack    = claim_ack_q;
  assign claim_id     = claim_id_q;
  assign clr_vld      = clr_vld_q;
  assign clr_id       = clr_id_q;
  assign cmpl_vld     = cmpl_vld_q;
  assign cmpl_id      = cmpl_id_q;
  assign best_id_flat = best_q;
  assign eip          = eip_q;

endmodule

// File: tb/tb_plic_claim_arbiter.sv
// Directed bench for plic_claim_arbiter: publish latency, thresholds, claims, completions, reset.
module tb_plic_claim_arbiter;

`ifdef PLIC_FAST_SCAN_EN
  localparam int LAT = (8 + 1) / 2 + 1;
`else
  localparam int LAT = 8 + 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      pending;
  logic [31:0][4:0] prio_a;
  logic [2:0][31:0] en_a;
  logic [2:0][4:0]  thr_a;
  logic [2:0]       claim_req, claim_ack, complete_req, eip;
  logic [4:0]       claim_id, clr_id, complete_id, cmpl_id;
  logic             clr_vld, cmpl_vld;
  logic [14:0]      best_id_flat;

  int errors = 0;
  int checks = 0;
  int rr_next = 0;

  typedef struct { logic [2:0] mask; logic [4:0] id; } exp_t;
  exp_t exp_q[$];

  plic_claim_arbiter #(.INTERRUPTS(8)) dut (
    .clk(clk), .rst(rst), .pending(pending), .prio_flat(prio_a), .enable_flat(en_a),
    .thresh_flat(thr_a), .claim_req(claim_req), .claim_ack(claim_ack), .claim_id(claim_id),
    .clr_vld(clr_vld), .clr_id(clr_id), .complete_req(complete_req), .complete_id(complete_id),
    .cmpl_vld(cmpl_vld), .cmpl_id(cmpl_id), .best_id_flat(best_id_flat), .eip(eip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1ns later, and act as the gateway dropping cleared pending bits.
  task automatic tick();
    @(posedge clk);
    #1;
    if (clr_vld) pending[clr_id] = 1'b0;
  endtask

  function automatic logic [4:0] ref_best(input int c);
    logic [4:0] b = '0;
    logic [4:0] bp = '0;
    for (int k = 1; k <= 8; k++) begin
      if (pending[k] && en_a[c][k] && prio_a[k] > thr_a[c] && prio_a[k] > bp) begin
        b  = 5'(k);
        bp = prio_a[k];
      end
    end
    return b;
  endfunction

  function automatic logic [14:0] ref_flat();
    return {ref_best(2), ref_best(1), ref_best(0)};
  endfunction

  task automatic push_claim(input int c, input logic [4:0] id);
    exp_t e;
    e.mask = 3'(1 << c);
    e.id   = id;
    exp_q.push_back(e);
    rr_next = (c + 1) % 3;
  endtask

  task automatic expect_claim(input string tag, input bit drop);
    exp_t e;
    int n = 0;
    do begin tick(); n++; end while (claim_ack == '0 && n < 4);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_ack"}, 32'(claim_ack), 32'(e.mask));
    chk({tag, "_id"}, 32'(claim_id), 32'(e.id));
    chk({tag, "_clr_vld"}, 32'(clr_vld), 32'(e.id != 0));
    chk({tag, "_clr_id"}, 32'(clr_id), 32'(e.id));
    if (drop) claim_req = claim_req & ~e.mask;
  endtask

  initial begin
    rst = 1'b0; pending = '0; prio_a = '0; en_a = '0; thr_a = '0;
    claim_req = '0; complete_req = '0; complete_id = '0;
    // Test 1 setup: src3/src5 at prio 5; ctx0/ctx1 see all, ctx2 only src5.
    prio_a[3] = 5'd5; prio_a[5] = 5'd5;
    en_a[0] = '1; en_a[1] = '1; en_a[2] = 32'h20;
    pending[3] = 1'b1; pending[5] = 1'b1;
    tick(); tick();
    chk("rst_claim_ack", 32'(claim_ack), 0);
    chk("rst_clr_vld", 32'(clr_vld), 0);
    chk("rst_cmpl_vld", 32'(cmpl_vld), 0);
    chk("rst_best", 32'(best_id_flat), 0);
    chk("rst_eip", 32'(eip), 0);
    #3 rst = 1'b1;

    for (int i = 0; i < LAT - 1; i++) tick();
    chk("t1_before_publish", 32'(best_id_flat), 0);
    tick();
    chk("t1_best0", 32'(best_id_flat[4:0]), 32'd3);
    chk("t1_eip", 32'(eip), 32'b111);
    chk("t1_best_all", 32'(best_id_flat), 32'({5'd5, 5'd3, 5'd3}));

    // Test 2: threshold equal to priority masks, one below admits.
    thr_a[0] = 5'd5;
    for (int i = 0; i < 2 * LAT; i++) tick();
    chk("t2_thr5_best0", 32'(best_id_flat[4:0]), 0);
    chk("t2_thr5_eip0", 32'(eip[0]), 0);
    thr_a[0] = 5'd4;
    for (int i = 0; i < 2 * LAT; i++) tick();
    chk("t2_thr4_best0", 32'(best_id_flat[4:0]), 32'd3);

    // Test 3: ctx0 and ctx1 claim the same ID together.
    claim_req = 3'b011;
    push_claim(0, 5'd3);
    push_claim(1, 5'd0);
    expect_claim("t3_first", 1'b1);
    chk("t3_zeroed", 32'(best_id_flat), 32'({5'd5, 5'd0, 5'd0}));
    chk("t3_eip", 32'(eip), 32'b100);
    expect_claim("t3_second", 1'b1);
    for (int i = 0; i < 2 * LAT; i++) tick();
    chk("t3_rescan", 32'(best_id_flat), 32'(ref_flat()));

    // Test 4: all contexts hold requests; grants rotate every cycle.
    claim_req = 3'b111;
    for (int i = 0; i < 6; i++) push_claim(rr_next, (i == 0) ? ref_best(rr_next) : 5'd0);
    for (int i = 0; i < 6; i++) expect_claim($sformatf("t4_g%0d", i), 1'b0);
    claim_req = '0;
    tick();
    chk("t4_idle", 32'(claim_ack), 0);

    // Test 5: completion filtering.
    en_a[1][7] = 1'b0;
    complete_req = 3'b010; complete_id = 5'd7;
    tick(); chk("t5_id7_drop", 32'(cmpl_vld), 0);
    complete_id = 5'd5;
    tick(); chk("t5_id5_vld", 32'(cmpl_vld), 1); chk("t5_id5_id", 32'(cmpl_id), 32'd5);
    complete_req = 3'b110; complete_id = 5'd7;
    tick(); chk("t5_lowest_ctx", 32'(cmpl_vld), 0);
    complete_req = 3'b001; complete_id = 5'd9;
    tick(); chk("t5_id_over", 32'(cmpl_vld), 0);
    complete_id = 5'd0;
    tick(); chk("t5_id0", 32'(cmpl_vld), 0);
    complete_req = 3'b001; complete_id = 5'd5; claim_req = 3'b100;
    push_claim(2, 5'd0);
    expect_claim("t5_both", 1'b1);
    chk("t5_both_cmpl", 32'(cmpl_vld), 1);
    chk("t5_both_cmpl_id", 32'(cmpl_id), 32'd5);
    complete_req = '0;

    // Test 6: async reset mid-scan with a claim held.
    pending[3] = 1'b1; pending[5] = 1'b1;
    for (int i = 0; i < 2 * LAT; i++) tick();
    chk("t6_pre_best", 32'(best_id_flat), 32'(ref_flat()));
    tick(); tick(); tick();
    claim_req = 3'b001;
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_best", 32'(best_id_flat), 0);
    chk("t6_rst_eip", 32'(eip), 0);
    chk("t6_rst_ack", 32'(claim_ack), 0);
    tick();
    chk("t6_rst_held_ack", 32'(claim_ack), 0);
    chk("t6_rst_held_clr", 32'(clr_vld), 0);
    claim_req = '0;
    #3 rst = 1'b1;
    for (int i = 0; i < LAT - 1; i++) tick();
    chk("t6_before_publish", 32'(best_id_flat), 0);
    tick();
    chk("t6_republish", 32'(best_id_flat), 32'(ref_flat()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
